// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and colour type shared by the scan controller.
package vga_timing_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned HFront  = 16;
  localparam int unsigned HSync   = 96;
  localparam int unsigned HBack   = 48;
  localparam int unsigned HTotal  = HActive + HFront + HSync + HBack;

  localparam int unsigned VActive = 480;
  localparam int unsigned VFront  = 10;
  localparam int unsigned VSync   = 2;
  localparam int unsigned VBack   = 33;
  localparam int unsigned VTotal  = VActive + VFront + VSync + VBack;

  // Sync windows as [start, end) in counter units.
  localparam int unsigned HSyncStart = HActive + HFront;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync;
  localparam int unsigned VSyncStart = VActive + VFront;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync;

  typedef logic [11:0] rgb_t;

  localparam rgb_t RgbWhite = 12'hFFF;
  localparam rgb_t RgbBlack = 12'h000;

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate strobe: one HCLK pulse every CLK_DIV cycles while enabled.
module vga_pixel_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic enable,
  output logic pix_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign pix_tick = enable && (cnt_q == CntMax);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (!enable || pix_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster scanner: h/v counters, memory addressing and registered display outputs
// that trail the counters by one pixel period.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 2,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        enable,
  input  logic        pixel,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] vga_rgb,
  output logic        frame_start
);

  localparam logic SyncIdle = SYNC_ACTIVE_LOW;

  logic       pix_tick;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_end, v_end, h_active, v_active, h_sync_win, v_sync_win;
  logic       hsync_q, vsync_q, video_on_q, frame_start_q;
  rgb_t       vga_rgb_q;

  vga_pixel_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .enable  (enable),
    .pix_tick(pix_tick)
  );

  assign h_end      = (h_cnt_q == 10'(HTotal - 1));
  assign v_end      = (v_cnt_q == 10'(VTotal - 1));
  assign h_active   = (h_cnt_q < 10'(HActive));
  assign v_active   = (v_cnt_q < 10'(VActive));
  assign h_sync_win = (h_cnt_q >= 10'(HSyncStart)) && (h_cnt_q < 10'(HSyncEnd));
  assign v_sync_win = (v_cnt_q >= 10'(VSyncStart)) && (v_cnt_q < 10'(VSyncEnd));

  assign pixel_x = h_active ? h_cnt_q : '0;
  assign pixel_y = v_active ? v_cnt_q[8:0] : '0;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (pix_tick) begin
      if (h_end) begin
        h_cnt_d = '0;
        v_cnt_d = v_end ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Display outputs sample the pre-update counters, so they trail the address by one pixel.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hsync_q    <= SyncIdle;
      vsync_q    <= SyncIdle;
      video_on_q <= 1'b0;
      vga_rgb_q  <= RgbBlack;
    end else if (!enable) begin
      hsync_q    <= SyncIdle;
      vsync_q    <= SyncIdle;
      video_on_q <= 1'b0;
      vga_rgb_q  <= RgbBlack;
    end else if (pix_tick) begin
      hsync_q    <= SyncIdle ^ h_sync_win;
      vsync_q    <= SyncIdle ^ v_sync_win;
      video_on_q <= h_active && v_active;
      vga_rgb_q  <= (h_active && v_active && pixel) ? RgbWhite : RgbBlack;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_tick && h_end && v_end;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign vga_rgb     = vga_rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller: line-0 vector table plus counter-jump corner cases.
module tb_vga_scan_controller;

  logic HCLK;
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Main instance: CLK_DIV=2, active-low syncs.
  logic        rst_n, enable, pixel;
  logic [9:0]  px;
  logic [8:0]  py;
  logic        hs, vs, von, fs;
  logic [11:0] rgb;

  // Second instance: CLK_DIV=4, active-high syncs.
  logic        rst4_n, en4, pix4;
  logic [9:0]  px4;
  logic [8:0]  py4;
  logic        hs4, vs4, von4, fs4;
  logic [11:0] rgb4;

  vga_scan_controller #(
    .CLK_DIV        (2),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (rst_n),
    .enable     (enable),
    .pixel      (pixel),
    .pixel_x    (px),
    .pixel_y    (py),
    .hsync      (hs),
    .vsync      (vs),
    .video_on   (von),
    .vga_rgb    (rgb),
    .frame_start(fs)
  );

  vga_scan_controller #(
    .CLK_DIV        (4),
    .SYNC_ACTIVE_LOW(1'b0)
  ) dut4 (
    .HCLK       (HCLK),
    .HRESETn    (rst4_n),
    .enable     (en4),
    .pixel      (pix4),
    .pixel_x    (px4),
    .pixel_y    (py4),
    .hsync      (hs4),
    .vsync      (vs4),
    .video_on   (von4),
    .vga_rgb    (rgb4),
    .frame_start(fs4)
  );

  // Pixel memory model: read data one HCLK after the address.
  int mode;
  always @(posedge HCLK) begin
    case (mode)
      0:       pixel <= (px == 10'd639) && (py == 9'd479);
      1:       pixel <= px[0];
      default: pixel <= 1'b1;
    endcase
  end

  int fs_count;
  initial fs_count = 0;
  always @(posedge HCLK) if (fs === 1'b1) fs_count++;

  int n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Back-door counter jump, applied where the next edge is not a pixel tick so the
  // register's own update keeps the forced value; afterwards the next edge is a tick.
  logic [9:0] jh, jv;
  task jump(input logic [9:0] h, input logic [9:0] v);
    jh = h;
    jv = v;
    for (int i = 0; i < 4 && dut.pix_tick; i++) @(negedge HCLK);
    force dut.h_cnt_q = jh;
    force dut.v_cnt_q = jv;
    @(negedge HCLK);
    release dut.h_cnt_q;
    release dut.v_cnt_q;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_px"}, px, 0);
    chk({tag, "_py"}, py, 0);
    chk({tag, "_von"}, von, 0);
    chk({tag, "_rgb"}, rgb, 12'h000);
    chk({tag, "_hs"}, hs, 1);
    chk({tag, "_vs"}, vs, 1);
    chk({tag, "_fs"}, fs, 0);
  endtask

  typedef struct {
    int          e;    // HCLK edges since enable rose
    logic [9:0]  px;
    logic [8:0]  py;
    logic        von;
    logic        hs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[14];
  int   cur;

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    rst4_n = 1'b0;
    en4    = 1'b0;
    pix4   = 1'b1;
    mode   = 1;

    // Line 0 with mode 1 (odd columns white); outputs trail the address by one pixel.
    vecs[0]  = '{1,    10'd0, 9'd0, 1'b0, 1'b1, 12'h000};
    vecs[1]  = '{2,    10'd1, 9'd0, 1'b1, 1'b1, 12'h000};
    vecs[2]  = '{4,    10'd2, 9'd0, 1'b1, 1'b1, 12'hFFF};
    vecs[3]  = '{5,    10'd2, 9'd0, 1'b1, 1'b1, 12'hFFF};
    vecs[4]  = '{6,    10'd3, 9'd0, 1'b1, 1'b1, 12'h000};
    vecs[5]  = '{1280, 10'd0, 9'd0, 1'b1, 1'b1, 12'hFFF};
    vecs[6]  = '{1282, 10'd0, 9'd0, 1'b0, 1'b1, 12'h000};
    vecs[7]  = '{1313, 10'd0, 9'd0, 1'b0, 1'b1, 12'h000};
    vecs[8]  = '{1314, 10'd0, 9'd0, 1'b0, 1'b0, 12'h000};
    vecs[9]  = '{1504, 10'd0, 9'd0, 1'b0, 1'b0, 12'h000};
    vecs[10] = '{1506, 10'd0, 9'd0, 1'b0, 1'b1, 12'h000};
    vecs[11] = '{1600, 10'd0, 9'd1, 1'b0, 1'b1, 12'h000};
    vecs[12] = '{1602, 10'd1, 9'd1, 1'b1, 1'b1, 12'h000};
    vecs[13] = '{1604, 10'd2, 9'd1, 1'b1, 1'b1, 12'hFFF};

    step(2);
    chk_idle("rst");
    chk("rst4_hs", hs4, 0);
    chk("rst4_vs", vs4, 0);
    chk("rst4_px", px4, 0);

    rst_n = 1'b1;
    step(1);
    chk("noen_px", px, 0);
    enable = 1'b1;
    cur = 0;
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].e - cur);
      cur = vecs[i].e;
      chk($sformatf("v%0d_px", i), px, vecs[i].px);
      chk($sformatf("v%0d_py", i), py, vecs[i].py);
      chk($sformatf("v%0d_von", i), von, vecs[i].von);
      chk($sformatf("v%0d_hs", i), hs, vecs[i].hs);
      chk($sformatf("v%0d_rgb", i), rgb, vecs[i].rgb);
      chk($sformatf("v%0d_vs", i), vs, 1);
    end
    chk("line_fs_count", fs_count, 0);

    enable = 1'b0;
    step(1);
    chk_idle("dis");
    enable = 1'b1;

    // Frame wrap.
    jump(10'd798, 10'd524);
    step(3);
    chk("wrap_fs", fs, 1);
    chk("wrap_px", px, 0);
    chk("wrap_py", py, 0);
    chk("wrap_vs", vs, 1);
    step(1);
    chk("wrap_fs_low", fs, 0);
    chk("wrap_fs_count", fs_count, 1);

    // Vertical sync spans lines 490..491.
    jump(10'd798, 10'd489);
    step(3);
    chk("vs_pre", vs, 1);
    chk("vs_py_blank", py, 0);
    step(2);
    chk("vs_on", vs, 0);
    chk("vs_von", von, 0);
    jump(10'd799, 10'd491);
    step(1);
    chk("vs_last", vs, 0);
    step(2);
    chk("vs_off", vs, 1);

    // Single lit pixel at the last address.
    mode = 0;
    jump(10'd638, 10'd479);
    step(1);
    chk("corner_px", px, 639);
    chk("corner_py", py, 479);
    chk("corner_rgb_before", rgb, 12'h000);
    step(2);
    chk("corner_rgb_on", rgb, 12'hFFF);
    step(1);
    chk("corner_rgb_hold", rgb, 12'hFFF);
    step(1);
    chk("corner_rgb_off", rgb, 12'h000);

    // Blanking with pixel forced high.
    mode = 2;
    jump(10'd700, 10'd100);
    chk("blank_px", px, 0);
    chk("blank_py", py, 100);
    step(1);
    chk("blank_von", von, 0);
    chk("blank_rgb", rgb, 12'h000);
    chk("blank_hs", hs, 0);

    // Mid-frame enable drop and restart.
    jump(10'd300, 10'd200);
    step(1);
    chk("mid_von", von, 1);
    chk("mid_rgb", rgb, 12'hFFF);
    chk("mid_px", px, 301);
    chk("mid_py", py, 200);
    enable = 1'b0;
    step(1);
    chk_idle("drop1");
    step(9);
    chk_idle("drop10");
    enable = 1'b1;
    step(1);
    chk("re_px0", px, 0);
    step(1);
    chk("re_px1", px, 1);
    chk("re_von", von, 1);
    chk("re_rgb", rgb, 12'hFFF);
    chk("re_fs_count", fs_count, 1);

    // CLK_DIV=4 instance: spacing, active-high sync, asynchronous reset mid-line.
    rst4_n = 1'b1;
    en4    = 1'b1;
    step(3);
    chk("d4_px_e3", px4, 0);
    step(1);
    chk("d4_px_e4", px4, 1);
    step(2624 - 4);
    chk("d4_hs_pre", hs4, 0);
    step(4);
    chk("d4_hs_on", hs4, 1);
    chk("d4_vs", vs4, 0);
    step(4406 - 2628);
    chk("d4_px", px4, 301);
    chk("d4_py", py4, 1);
    chk("d4_von", von4, 1);
    chk("d4_rgb", rgb4, 12'hFFF);
    #2 rst4_n = 1'b0;
    #1;
    chk("d4r_px", px4, 0);
    chk("d4r_py", py4, 0);
    chk("d4r_von", von4, 0);
    chk("d4r_rgb", rgb4, 12'h000);
    chk("d4r_hs", hs4, 0);
    chk("d4r_vs", vs4, 0);
    chk("d4r_fs", fs4, 0);
    @(negedge HCLK);
    rst4_n = 1'b1;
    step(3);
    chk("d4s_px_e3", px4, 0);
    step(1);
    chk("d4s_px_e4", px4, 1);
    step(3);
    chk("d4s_px_e7", px4, 1);
    step(1);
    chk("d4s_px_e8", px4, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, HCLK cycles per pixel; legal range 2..8.
REQ-002 SHALL have parameter SYNC_ACTIVE_LOW, default 1, giving hsync/vsync polarity.
REQ-003 HCLK  input  1  sole clock; all state on its rising edge.
REQ-004 HRESETn  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  scan run control; low forces idle.
REQ-006 pixel  input  1  pixel memory read data, valid one HCLK after pixel_x/pixel_y present.
REQ-007 pixel_x  output  10  memory read column address.
REQ-008 pixel_y  output  9  memory read row address.
REQ-009 hsync  output  1  horizontal sync to display.
REQ-010 vsync  output  1  vertical sync to display.
REQ-011 video_on  output  1  high while the displayed pixel is active.
REQ-012 vga_rgb  output  12  4:4:4 colour; 12'hFFF for pixel=1, 12'h000 otherwise or when blanked.
REQ-013 frame_start  output  1  one-HCLK pulse when counters wrap to (0,0).

Function
REQ-014 Tick counter SHALL count 0..CLK_DIV-1 and assert pix_tick for one HCLK when at CLK_DIV-1, then wrap to 0.
REQ-015 h_cnt SHALL advance 0..799 on pix_tick; at 799 wrap to 0 and advance v_cnt.
REQ-016 v_cnt SHALL advance 0..524; at h=799,v=524 both wrap to 0 in the same tick and frame_start pulses on that HCLK.
REQ-017 Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-018 Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-019 pixel_x SHALL equal h_cnt when h_cnt<640, else 0; pixel_y SHALL equal v_cnt when v_cnt<480, else 0; max address 639+479*640=307199.
REQ-020 pixel_x/pixel_y SHALL be combinational from counters, stable for the full CLK_DIV-cycle pixel period.
REQ-021 On each pix_tick, output registers SHALL load hsync, vsync, video_on and vga_rgb computed from pre-update (h_cnt,v_cnt) and the current pixel input.
REQ-022 Display outputs therefore lag counters by exactly one pixel period (CLK_DIV HCLK cycles).
REQ-023 hsync/vsync SHALL assert at the SYNC_ACTIVE_LOW polarity only inside their sync windows.
REQ-024 enable low SHALL hold all counters at 0 and force video_on=0, vga_rgb=0, syncs inactive, frame_start=0 on the next HCLK.
REQ-025 enable rising SHALL restart scan at (0,0) with tick counter 0; first pix_tick after CLK_DIV cycles.
REQ-026 Mid-frame enable deassertion SHALL abandon the frame; no partial-frame frame_start.

Reset
REQ-027 HRESETn low SHALL asynchronously clear tick, h_cnt and v_cnt to 0.
REQ-028 In reset: pixel_x=0, pixel_y=0, video_on=0, vga_rgb=0, frame_start=0, hsync/vsync inactive.
REQ-029 After reset release scan SHALL start only when enable=1, following REQ-025.

Structure
REQ-030 Timing constants (H/V active, porch, sync, total) and the rgb_t 12-bit typedef SHALL reside in package vga_timing_pkg.
REQ-031 Tick generation SHALL be sub-module vga_pixel_tick (HCLK, HRESETn, enable, pix_tick).
REQ-032 No combinational path SHALL exist from pixel to any output.

Verification
REQ-033 Reset then enable=1, CLK_DIV=2 -> first pix_tick at HCLK 2; h_cnt=1 after it; hsync first active at h_cnt=656, width 96 ticks (192 HCLK).
REQ-034 Run one full frame -> exactly 420000 pix_ticks between frame_start pulses; vsync active for 2 lines (1600 ticks).
REQ-035 Memory model returns 1 only at address (639,479) -> vga_rgb=12'hFFF for exactly one pixel period, one tick after counters reach (639,479).
REQ-036 Counters in blanking (h=700,v=100) -> pixel_x=0, pixel_y=100, video_on=0, vga_rgb=0 with pixel=1.
REQ-037 enable dropped at (300,200), reasserted 10 cycles later -> outputs idle while low; restart at (0,0); no frame_start until full frame completes.
REQ-038 HRESETn asserted mid-line with CLK_DIV=4 -> all outputs at reset values asynchronously; tick spacing 4 HCLK after restart.
